memory_stage: RTL and testbench

//  Memory-access stage between Execute and Write-Back of the 5-stage RISC pipeline.

---
 rtl/memory_stage_if.sv | 39 +++
 rtl/memory_stage.sv | 225 ++++++++++++++++++++++
 tb/tb_memory_stage.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/memory_stage_if.sv
// Bus between the EX/MEM pipeline register and the memory stage, plus the stage's
// write-back, return-address and stack-pointer results.
interface memory_stage_if #(
    parameter int ADDR_W = 12
);
    // Handshake: an op is consumed on a rising edge where in_valid=1 and stall=0.
    // While stall=1 the stage ignores in_valid and the producer holds its contents.
    logic              in_valid;
    logic [3:0]        op;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       wdata;
    logic [15:0]       alu_result;
    logic [31:0]       pc_in;
    logic [2:0]        ccr_in;
    logic [2:0]        rd_in;
    logic              reg_wr_in;
    logic              stall;
    logic              wb_valid;
    logic [15:0]       wb_data;
    logic [2:0]        wb_rd;
    logic [31:0]       pc_out;
    logic              pc_valid;
    logic [2:0]        ccr_out;
    logic              ccr_valid;
    logic [ADDR_W-1:0] sp_out;
    logic [2:0]        fsm_state;

    modport master (
        output in_valid, op, addr, wdata, alu_result, pc_in, ccr_in, rd_in, reg_wr_in,
        input  stall, wb_valid, wb_data, wb_rd, pc_out, pc_valid, ccr_out, ccr_valid,
               sp_out, fsm_state
    );

    modport slave (
        input  in_valid, op, addr, wdata, alu_result, pc_in, ccr_in, rd_in, reg_wr_in,
        output stall, wb_valid, wb_data, wb_rd, pc_out, pc_valid, ccr_out, ccr_valid,
               sp_out, fsm_state
    );
endinterface

// File: rtl/memory_stage.sv
// Memory stage: data memory, downward-growing stack, and sequencing of the
// multi-word CALL/INT pushes and RET/RTI pops with registered results.
module memory_stage #(
    parameter int                ADDR_W = 12,
    parameter logic [ADDR_W-1:0] SP_RST = {ADDR_W{1'b1}}
) (
    input logic           clk,
    input logic           rst,
    memory_stage_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;

    localparam logic [3:0] OP_LOAD  = 4'd1;
    localparam logic [3:0] OP_STORE = 4'd2;
    localparam logic [3:0] OP_PUSH  = 4'd3;
    localparam logic [3:0] OP_POP   = 4'd4;
    localparam logic [3:0] OP_CALL  = 4'd5;
    localparam logic [3:0] OP_RET   = 4'd6;
    localparam logic [3:0] OP_INT   = 4'd7;
    localparam logic [3:0] OP_RTI   = 4'd8;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        PUSH_LO    = 3'd1,
        PUSH_PC_HI = 3'd2,
        POP_HI     = 3'd3,
        POP_CCR    = 3'd4
    } state_t;

    state_t state, state_nxt;

    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] sp, sp_nxt;
    logic [31:0]       pc_lat, pc_lat_nxt;
    logic [15:0]       lo_lat, lo_nxt, hi_lat, hi_nxt;
    logic              rti_lat, rti_nxt;

    logic              wb_valid_q, wb_valid_nxt;
    logic [15:0]       wb_data_q, wb_data_nxt;
    logic [2:0]        wb_rd_q, wb_rd_nxt;
    logic [31:0]       pc_out_q, pc_out_nxt;
    logic              pc_valid_q, pc_valid_nxt;
    logic [2:0]        ccr_out_q, ccr_out_nxt;
    logic              ccr_valid_q, ccr_valid_nxt;

    logic              accept;
    logic              do_push, do_pop;
    logic [15:0]       push_data, pop_data;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [15:0]       mem_wdata;

    assign accept   = bus.in_valid && (state == IDLE);
    assign pop_data = mem[sp + ADDR_W'(1)];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    case (bus.op)
                        OP_CALL:        state_nxt = PUSH_LO;
                        OP_INT:         state_nxt = PUSH_PC_HI;
                        OP_RET, OP_RTI: state_nxt = POP_HI;
                        default:        state_nxt = IDLE;
                    endcase
                end
            end
            PUSH_PC_HI: state_nxt = PUSH_LO;
            PUSH_LO:    state_nxt = IDLE;
            POP_HI:     state_nxt = rti_lat ? POP_CCR : IDLE;
            POP_CCR:    state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Output / datapath-control logic: one stack word moves per cycle at most
    always_comb begin
        do_push       = 1'b0;
        push_data     = 16'h0000;
        do_pop        = 1'b0;
        mem_we        = 1'b0;
        mem_waddr     = bus.addr;
        mem_wdata     = bus.wdata;
        sp_nxt        = sp;
        wb_valid_nxt  = 1'b0;
        wb_data_nxt   = wb_data_q;
        wb_rd_nxt     = wb_rd_q;
        pc_out_nxt    = pc_out_q;
        pc_valid_nxt  = 1'b0;
        ccr_out_nxt   = ccr_out_q;
        ccr_valid_nxt = 1'b0;
        pc_lat_nxt    = pc_lat;
        lo_nxt        = lo_lat;
        hi_nxt        = hi_lat;
        rti_nxt       = rti_lat;
        case (state)
            IDLE: begin
                if (accept) begin
                    wb_rd_nxt = bus.rd_in;
                    case (bus.op)
                        OP_LOAD: begin
                            wb_data_nxt  = mem[bus.addr];
                            wb_valid_nxt = bus.reg_wr_in;
                        end
                        OP_STORE: mem_we = 1'b1;
                        OP_PUSH: begin
                            do_push   = 1'b1;
                            push_data = bus.wdata;
                        end
                        OP_POP: begin
                            do_pop       = 1'b1;
                            wb_data_nxt  = pop_data;
                            wb_valid_nxt = bus.reg_wr_in;
                        end
                        OP_CALL: begin
                            do_push    = 1'b1;
                            push_data  = bus.pc_in[31:16];
                            pc_lat_nxt = bus.pc_in;
                        end
                        OP_INT: begin
                            do_push    = 1'b1;
                            push_data  = {13'b0, bus.ccr_in};
                            pc_lat_nxt = bus.pc_in;
                        end
                        OP_RET, OP_RTI: begin
                            do_pop  = 1'b1;
                            lo_nxt  = pop_data;
                            rti_nxt = (bus.op == OP_RTI);
                        end
                        default: begin
                            wb_data_nxt  = bus.alu_result;
                            wb_valid_nxt = bus.reg_wr_in;
                        end
                    endcase
                end
            end
            PUSH_PC_HI: begin
                do_push   = 1'b1;
                push_data = pc_lat[31:16];
            end
            PUSH_LO: begin
                do_push   = 1'b1;
                push_data = pc_lat[15:0];
            end
            POP_HI: begin
                do_pop = 1'b1;
                if (rti_lat) begin
                    hi_nxt = pop_data;
                end else begin
                    pc_out_nxt   = {pop_data, lo_lat};
                    pc_valid_nxt = 1'b1;
                end
            end
            POP_CCR: begin
                do_pop        = 1'b1;
                pc_out_nxt    = {hi_lat, lo_lat};
                pc_valid_nxt  = 1'b1;
                ccr_out_nxt   = pop_data[2:0];
                ccr_valid_nxt = 1'b1;
            end
            default: ;
        endcase
        if (do_push) begin
            mem_we    = 1'b1;
            mem_waddr = sp;
            mem_wdata = push_data;
            sp_nxt    = sp - ADDR_W'(1);
        end
        if (do_pop) sp_nxt = sp + ADDR_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sp          <= SP_RST;
            pc_lat      <= 32'h0;
            lo_lat      <= 16'h0;
            hi_lat      <= 16'h0;
            rti_lat     <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= 16'h0;
            wb_rd_q     <= 3'h0;
            pc_out_q    <= 32'h0;
            pc_valid_q  <= 1'b0;
            ccr_out_q   <= 3'h0;
            ccr_valid_q <= 1'b0;
        end else begin
            sp          <= sp_nxt;
            pc_lat      <= pc_lat_nxt;
            lo_lat      <= lo_nxt;
            hi_lat      <= hi_nxt;
            rti_lat     <= rti_nxt;
            wb_valid_q  <= wb_valid_nxt;
            wb_data_q   <= wb_data_nxt;
            wb_rd_q     <= wb_rd_nxt;
            pc_out_q    <= pc_out_nxt;
            pc_valid_q  <= pc_valid_nxt;
            ccr_out_q   <= ccr_out_nxt;
            ccr_valid_q <= ccr_valid_nxt;
        end
    end

    // Memory contents survive reset; only the write is suppressed while rst is high
    always_ff @(posedge clk) begin
        if (!rst && mem_we) mem[mem_waddr] <= mem_wdata;
    end

    assign bus.stall     = (state != IDLE);
    assign bus.wb_valid  = wb_valid_q;
    assign bus.wb_data   = wb_data_q;
    assign bus.wb_rd     = wb_rd_q;
    assign bus.pc_out    = pc_out_q;
    assign bus.pc_valid  = pc_valid_q;
    assign bus.ccr_out   = ccr_out_q;
    assign bus.ccr_valid = ccr_valid_q;
    assign bus.sp_out    = sp;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_memory_stage.sv
// Bench for memory_stage: directed scenarios then random ops, all checked against
// a word-level stack/memory model.
module tb_memory_stage;
    localparam int ADDR_W = 12;
    localparam logic [3:0] NOP = 4'd0, LOAD = 4'd1, STORE = 4'd2, PUSH = 4'd3, POP = 4'd4,
                           CALL = 4'd5, RET = 4'd6, INT = 4'd7, RTI = 4'd8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    memory_stage_if #(.ADDR_W(ADDR_W)) bus ();
    memory_stage #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    int          n_checks = 0;
    int          n_pass = 0;
    logic [15:0] exp_q[$];
    logic [15:0] ref_mem [4096];
    bit          ref_known [4096];
    logic [11:0] ref_sp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic m_push(input logic [15:0] d);
        ref_mem[ref_sp]   = d;
        ref_known[ref_sp] = 1'b1;
        ref_sp            = ref_sp - 12'd1;
    endtask

    task automatic m_pop(output logic [15:0] d);
        ref_sp = ref_sp + 12'd1;
        d      = ref_mem[ref_sp];
    endtask

    task automatic drive_idle();
        bus.in_valid   = 1'b0;
        bus.op         = NOP;
        bus.addr       = '0;
        bus.wdata      = '0;
        bus.alu_result = '0;
        bus.pc_in      = '0;
        bus.ccr_in     = '0;
        bus.rd_in      = '0;
        bus.reg_wr_in  = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        drive_idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst    = 1'b0;
        ref_sp = 12'hFFF;
    endtask

    // Issue one op, wait out any stall (bounded), then compare against the model
    task automatic run_op(input logic [3:0] op, input logic [11:0] a, input logic [15:0] d,
                          input logic [15:0] alu, input logic [31:0] pc, input logic [2:0] ccr,
                          input logic [2:0] rd, input logic we);
        logic [15:0] exp_wb, lo, hi, c;
        logic        exp_wbv;
        logic [31:0] exp_pc;
        logic [2:0]  exp_ccr;
        int          exp_stall, stalls;
        bit          is_ret;
        exp_wbv = 1'b0; exp_wb = '0; exp_stall = 0; exp_pc = '0; exp_ccr = '0;
        case (op)
            LOAD:  begin exp_wb = ref_mem[a]; exp_wbv = we; end
            STORE: begin ref_mem[a] = d; ref_known[a] = 1'b1; end
            PUSH:  m_push(d);
            POP:   begin m_pop(exp_wb); exp_wbv = we; end
            CALL:  begin m_push(pc[31:16]); m_push(pc[15:0]); exp_stall = 1; end
            INT:   begin m_push({13'b0, ccr}); m_push(pc[31:16]); m_push(pc[15:0]); exp_stall = 2; end
            RET:   begin m_pop(lo); m_pop(hi); exp_pc = {hi, lo}; exp_stall = 1; end
            RTI:   begin m_pop(lo); m_pop(hi); m_pop(c); exp_pc = {hi, lo}; exp_ccr = c[2:0]; exp_stall = 2; end
            default: begin exp_wb = alu; exp_wbv = we; end
        endcase
        if (exp_wbv) exp_q.push_back(exp_wb);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = op; bus.addr = a; bus.wdata = d; bus.alu_result = alu;
        bus.pc_in = pc; bus.ccr_in = ccr; bus.rd_in = rd; bus.reg_wr_in = we;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.pc_in    = $urandom;
        bus.ccr_in   = 3'($urandom_range(0, 7));
        bus.wdata    = 16'($urandom);
        stalls = 0;
        while (bus.stall && stalls < 8) begin
            check("pulse_during_stall", {31'b0, bus.pc_valid}, 32'd0);
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.op       = PUSH;
            stalls++;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        check("stall_cycles", stalls, exp_stall);
        check("sp_out", {20'b0, bus.sp_out}, {20'b0, ref_sp});
        check("wb_valid", {31'b0, bus.wb_valid}, {31'b0, exp_wbv});
        if (exp_wbv) begin
            check("wb_data", {16'b0, bus.wb_data}, {16'b0, exp_q.pop_front()});
            check("wb_rd", {29'b0, bus.wb_rd}, {29'b0, rd});
        end
        is_ret = (op == RET) || (op == RTI);
        check("pc_valid", {31'b0, bus.pc_valid}, {31'b0, is_ret});
        check("ccr_valid", {31'b0, bus.ccr_valid}, {31'b0, op == RTI});
        if (is_ret) check("pc_out", bus.pc_out, exp_pc);
        if (op == RTI) check("ccr_out", {29'b0, bus.ccr_out}, {29'b0, exp_ccr});
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [11:0] s1, s2, s3, a;
        logic [3:0]  op;
        int          sel;
        rst = 1'b1;
        drive_idle();
        for (int i = 0; i < 4096; i++) ref_known[i] = 1'b0;

        // Reset values
        apply_reset();
        check("rst_sp", {20'b0, bus.sp_out}, 32'hFFF);
        check("rst_stall", {31'b0, bus.stall}, 32'd0);
        check("rst_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
        check("rst_pc_valid", {31'b0, bus.pc_valid}, 32'd0);
        check("rst_ccr_valid", {31'b0, bus.ccr_valid}, 32'd0);
        check("rst_pc_out", bus.pc_out, 32'd0);

        // Store then load
        run_op(STORE, 12'h010, 16'hBEEF, 16'h0, 32'h0, 3'h0, 3'd0, 1'b0);
        run_op(LOAD, 12'h010, 16'h0, 16'h0, 32'h0, 3'h0, 3'd3, 1'b1);
        check("t2_wb_data", {16'b0, bus.wb_data}, 32'hBEEF);

        // Stack push/pop ordering
        run_op(PUSH, 12'h0, 16'h1111, 16'h0, 32'h0, 3'h0, 3'd0, 1'b0);
        run_op(PUSH, 12'h0, 16'h2222, 16'h0, 32'h0, 3'h0, 3'd0, 1'b0);
        check("t3_sp_low", {20'b0, bus.sp_out}, 32'hFFD);
        run_op(POP, 12'h0, 16'h0, 16'h0, 32'h0, 3'h0, 3'd1, 1'b1);
        check("t3_pop1", {16'b0, bus.wb_data}, 32'h2222);
        run_op(POP, 12'h0, 16'h0, 16'h0, 32'h0, 3'h0, 3'd2, 1'b1);
        check("t3_pop2", {16'b0, bus.wb_data}, 32'h1111);

        // CALL / RET
        run_op(CALL, 12'h0, 16'h0, 16'h0, 32'h0001_2345, 3'h0, 3'd0, 1'b0);
        check("t4_sp", {20'b0, bus.sp_out}, 32'hFFD);
        run_op(LOAD, 12'hFFF, 16'h0, 16'h0, 32'h0, 3'h0, 3'd4, 1'b1);
        check("t4_mem_fff", {16'b0, bus.wb_data}, 32'h0001);
        run_op(LOAD, 12'hFFE, 16'h0, 16'h0, 32'h0, 3'h0, 3'd4, 1'b1);
        check("t4_mem_ffe", {16'b0, bus.wb_data}, 32'h2345);
        run_op(RET, 12'h0, 16'h0, 16'h0, 32'h0, 3'h0, 3'd0, 1'b0);
        check("t4_pc_out", bus.pc_out, 32'h0001_2345);

        // INT / RTI
        run_op(INT, 12'h0, 16'h0, 16'h0, 32'h0000_0400, 3'b101, 3'd0, 1'b0);
        run_op(RTI, 12'h0, 16'h0, 16'h0, 32'h0, 3'h0, 3'd0, 1'b0);
        check("t5_pc_out", bus.pc_out, 32'h400);
        check("t5_ccr_out", {29'b0, bus.ccr_out}, 32'h5);
        check("t5_sp", {20'b0, bus.sp_out}, 32'hFFF);

        // Reset in the middle of a RET, then stack-pointer wrap both ways
        run_op(CALL, 12'h0, 16'h0, 16'h0, 32'hCAFE_0123, 3'h0, 3'd0, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.op = RET;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        check("t6_mid_stall", {31'b0, bus.stall}, 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst    = 1'b0;
        ref_sp = 12'hFFF;
        check("t6_no_pulse", {31'b0, bus.pc_valid}, 32'd0);
        check("t6_sp", {20'b0, bus.sp_out}, 32'hFFF);
        check("t6_stall", {31'b0, bus.stall}, 32'd0);
        @(posedge clk); #1;
        check("t6_no_late_pulse", {31'b0, bus.pc_valid}, 32'd0);
        run_op(STORE, 12'h000, 16'hA5A5, 16'h0, 32'h0, 3'h0, 3'd0, 1'b0);
        run_op(POP, 12'h0, 16'h0, 16'h0, 32'h0, 3'h0, 3'd5, 1'b1);
        check("t6_wrap_pop", {16'b0, bus.wb_data}, 32'hA5A5);
        check("t6_wrap_sp", {20'b0, bus.sp_out}, 32'h000);
        run_op(PUSH, 12'h0, 16'h7777, 16'h0, 32'h0, 3'h0, 3'd0, 1'b0);
        check("t6_push_wrap_sp", {20'b0, bus.sp_out}, 32'hFFF);
        run_op(LOAD, 12'h000, 16'h0, 16'h0, 32'h0, 3'h0, 3'd6, 1'b1);
        check("t6_mem0", {16'b0, bus.wb_data}, 32'h7777);

        // Random traffic; pops only where the model knows the memory contents
        for (int i = 0; i < 400; i++) begin
            s1  = ref_sp + 12'd1;
            s2  = ref_sp + 12'd2;
            s3  = ref_sp + 12'd3;
            a   = 12'($urandom_range(0, 255));
            sel = $urandom_range(0, 9);
            case (sel)
                0: op = $urandom_range(0, 1) ? NOP : 4'($urandom_range(9, 15));
                1: op = ref_known[a] ? LOAD : STORE;
                2: op = STORE;
                3: op = PUSH;
                4: op = ref_known[s1] ? POP : PUSH;
                5: op = CALL;
                6: op = (ref_known[s1] && ref_known[s2]) ? RET : PUSH;
                7: op = INT;
                8: op = (ref_known[s1] && ref_known[s2] && ref_known[s3]) ? RTI : PUSH;
                default: op = NOP;
            endcase
            if (sel == 9) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.op       = 4'($urandom_range(0, 15));
                bus.wdata    = 16'($urandom);
                @(posedge clk); #1;
                check("idle_wb_valid", {31'b0, bus.wb_valid}, 32'd0);
                check("idle_sp", {20'b0, bus.sp_out}, {20'b0, ref_sp});
            end else begin
                run_op(op, a, 16'($urandom), 16'($urandom), $urandom,
                       3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                       1'($urandom_range(0, 1)));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
